// File: rtl/cy_clken_scheduler.sv
// cy_clken_scheduler: round-robin owner of one shared clock enable.
// A granted requester gets a burst of burst_len enabled cycles (0 means
// 2^BurstWidth). The burst may be paused with hold or aborted by dropping
// req. Every grant ends with a one-cycle GAP before the next arbitration.
`timescale 1ns/1ps
module cy_clken_scheduler #(
  parameter int NumReq     = 4,
  parameter int BurstWidth = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [3:0]            req,
  input  logic [BurstWidth-1:0] burst_len,
  input  logic                  hold,
  output logic                  en_out,
  output logic [3:0]            grant,
  output logic                  busy,
  output logic [3:0]            done
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  localparam logic [BurstWidth:0] CntOne = {{BurstWidth{1'b0}}, 1'b1};

  state_t              state_q;
  logic [3:0]          grant_q;
  logic [3:0]          done_q;
  logic [1:0]          owner_q;
  logic [1:0]          ptr_q;
  logic [BurstWidth:0] cnt_q;

  logic [3:0]          req_valid;
  logic                found_d;
  logic [1:0]          pick_d;
  logic [2:0]          idx_d;
  logic [1:0]          ptr_adv_d;
  logic [BurstWidth:0] cnt_load_d;

  // Requesters at or above NumReq are masked off so they can never win.
  for (genvar gi = 0; gi < 4; gi++) begin : g_req_mask
    if (gi < NumReq) begin : g_live
      assign req_valid[gi] = req[gi];
    end else begin : g_dead
      assign req_valid[gi] = 1'b0;
    end
  end

  // Round-robin search: first valid requester at or after ptr, with wrap.
  always_comb begin
    found_d = 1'b0;
    pick_d  = ptr_q;
    idx_d   = 3'd0;
    for (int k = 0; k < NumReq; k++) begin
      idx_d = {1'b0, ptr_q} + 3'(k);
      if (idx_d >= 3'(NumReq)) begin
        idx_d = idx_d - 3'(NumReq);
      end
      if (!found_d && req_valid[idx_d[1:0]]) begin
        found_d = 1'b1;
        pick_d  = idx_d[1:0];
      end
    end
  end

  // Pointer after the current owner finishes, and the burst length to load.
  always_comb begin
    ptr_adv_d  = (owner_q == 2'(NumReq - 1)) ? 2'd0 : owner_q + 2'd1;
    cnt_load_d = (burst_len == '0) ? {1'b1, {BurstWidth{1'b0}}} : {1'b0, burst_len};
  end

  // The enable follows hold combinationally, but only while a burst runs.
  assign en_out = (state_q == RUN) && !hold;
  assign busy   = |grant_q;
  assign grant  = grant_q;
  assign done   = done_q;

  // Scheduler FSM: arbitrate, count enabled cycles, finish or abort into GAP.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE, GAP: begin
          if (found_d) begin
            state_q <= RUN;
            owner_q <= pick_d;
            grant_q <= 4'b0001 << pick_d;
            cnt_q   <= cnt_load_d;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (en_out && (cnt_q == CntOne)) begin
            // Last enabled cycle wins over a simultaneous req drop.
            done_q  <= grant_q;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= ptr_adv_d;
            state_q <= GAP;
          end else if (!req_valid[owner_q]) begin
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= ptr_adv_d;
            state_q <= GAP;
          end else if (en_out) begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cy_clken_scheduler.sv
// Testbench for cy_clken_scheduler: directed scenarios plus randomized
// traffic, all checked against a burst-level reference model.
`timescale 1ns/1ps
module tb_cy_clken_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [7:0] burst_len;
  logic       hold;
  logic       en_out;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] done;

  logic [3:0] req2;
  logic       en2;
  logic [3:0] grant2;
  logic       busy2;
  logic [3:0] done2;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = none), remaining enabled cycles,
  // round-robin pointer, pending done pulse, and the owner's burst length.
  int         m_owner = -1;
  int         m_cnt   = 0;
  int         m_ptr   = 0;
  logic [3:0] m_done  = '0;
  int         m_len   = 0;
  int         en_acc  = 0;

  logic [3:0] obs_grant;
  logic       obs_en;
  logic       obs_busy;
  logic [3:0] obs_done;

  cy_clken_scheduler #(.NumReq(4), .BurstWidth(8)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .burst_len(burst_len),
    .hold(hold), .en_out(en_out), .grant(grant), .busy(busy), .done(done)
  );

  cy_clken_scheduler #(.NumReq(2), .BurstWidth(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .req(req2), .burst_len(burst_len),
    .hold(hold), .en_out(en2), .grant(grant2), .busy(busy2), .done(done2)
  );

  always #5 clock = ~clock;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    int idx;
    if (!reset_n) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_done = '0; en_acc = 0;
    end else if (m_owner >= 0) begin
      m_done = '0;
      if (!hold && m_cnt == 1) begin
        m_done[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (!hold) begin
        m_cnt = m_cnt - 1;
      end
    end else begin
      m_done = '0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && req[idx]) begin
          m_owner = idx;
          m_cnt   = (burst_len == 0) ? 256 : int'(burst_len);
          m_len   = m_cnt;
          en_acc  = 0;
        end
      end
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then take the edge.
  task automatic step();
    logic [3:0] exp_grant;
    logic       exp_en;
    @(negedge clock);
    obs_grant = grant; obs_en = en_out; obs_busy = busy; obs_done = done;
    exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    exp_en    = (m_owner >= 0) && !hold;
    n_vec++;
    if ({obs_grant, obs_busy, obs_en, obs_done} !== {exp_grant, (m_owner >= 0), exp_en, m_done}) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t: grant=%b busy=%b en=%b done=%b, expected grant=%b busy=%b en=%b done=%b",
               $time, obs_grant, obs_busy, obs_en, obs_done, exp_grant, (m_owner >= 0), exp_en, m_done);
    end
    n_vec++;
    if (!$onehot0(obs_grant) || (obs_en && obs_grant == 4'b0000)) begin
      n_err++;
      $display("FAIL grant_invariant t=%0t: grant=%b en=%b, expected onehot0 grant and no enable without grant",
               $time, obs_grant, obs_en);
    end
    if (obs_en === 1'b1) en_acc++;
    if (obs_done !== 4'b0000) begin
      n_vec++;
      if (en_acc != m_len) begin
        n_err++;
        $display("FAIL burst_total t=%0t: done=%b after %0d enabled cycles, expected %0d", $time, obs_done, en_acc, m_len);
      end else begin
        $display("burst done=%b enabled cycles=%0d", obs_done, en_acc);
      end
    end
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111; req2 = 4'b0000; burst_len = 8'd3; hold = 1'b0;
    @(posedge clock); #1;
    model_update();
    step();
    step();
    n_vec++;
    if ({obs_grant, obs_busy, obs_en, obs_done} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_state: grant=%b busy=%b en=%b done=%b, expected all zero", obs_grant, obs_busy, obs_en, obs_done);
    end
    req = 4'b0000;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; burst_len = 8'd3; hold = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({obs_grant, obs_en, obs_done} !== {4'b0001, 1'b1, 4'b0000}) begin
        n_err++;
        $display("FAIL single_run%0d: grant=%b en=%b done=%b, expected grant=0001 en=1 done=0000", i, obs_grant, obs_en, obs_done);
      end
    end
    req = 4'b0000;
    step();
    n_vec++;
    if ({obs_grant, obs_en, obs_done} !== {4'b0000, 1'b0, 4'b0001}) begin
      n_err++;
      $display("FAIL single_done: grant=%b en=%b done=%b, expected grant=0000 en=0 done=0001", obs_grant, obs_en, obs_done);
    end
    step();
    n_vec++;
    if ({obs_grant, obs_busy, obs_done} !== 9'b0) begin
      n_err++;
      $display("FAIL single_idle: grant=%b busy=%b done=%b, expected all zero", obs_grant, obs_busy, obs_done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order[$];
    logic [3:0] prev;
    logic [3:0] want;
    logic [19:0] want_all;
    apply_reset();
    req = 4'b1111; burst_len = 8'd2; hold = 1'b0;
    prev = 4'b0000;
    want_all = 20'b0001_1000_0100_0010_0001;
    for (int c = 0; c < 16; c++) begin
      step();
      if (obs_grant != 4'b0000 && prev == 4'b0000) order.push_back(obs_grant);
      prev = obs_grant;
    end
    req = 4'b0000;
    n_vec++;
    if (order.size() < 5) begin
      n_err++;
      $display("FAIL rr_count: %0d grants seen, expected at least 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = want_all[i*4 +: 4];
        n_vec++;
        if (order[i] !== want) begin
          n_err++;
          $display("FAIL rr_order%0d: grant=%b, expected %b", i, order[i], want);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_hold();
    int  en_cnt;
    bit  seen;
    apply_reset();
    req = 4'b0010; burst_len = 8'd4; hold = 1'b0;
    step();
    burst_len = 8'd9;
    en_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (obs_en) en_cnt++;
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({obs_en, obs_grant, obs_busy} !== {1'b0, 4'b0010, 1'b1}) begin
        n_err++;
        $display("FAIL hold_pause%0d: en=%b grant=%b busy=%b, expected en=0 grant=0010 busy=1", i, obs_en, obs_grant, obs_busy);
      end
    end
    hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (obs_en) en_cnt++;
      if (obs_done != 4'b0000) seen = 1'b1;
    end
    req = 4'b0000;
    n_vec++;
    if (!seen || obs_done !== 4'b0010 || en_cnt != 4) begin
      n_err++;
      $display("FAIL hold_total: done=%b enabled=%0d, expected done=0010 enabled=4", obs_done, en_cnt);
    end
    step();
  endtask

  task automatic test_zero_length();
    int en_cnt;
    bit seen;
    apply_reset();
    req = 4'b0001; burst_len = 8'd0; hold = 1'b0;
    step();
    burst_len = 8'd7;
    en_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (obs_en) en_cnt++;
      if (obs_done != 4'b0000) seen = 1'b1;
    end
    req = 4'b0000;
    n_vec++;
    if (!seen || en_cnt != 256) begin
      n_err++;
      $display("FAIL zero_length: done_seen=%0d enabled=%0d, expected done_seen=1 enabled=256", seen, en_cnt);
    end
    step();
  endtask

  task automatic test_abort_and_reset();
    apply_reset();
    req = 4'b0100; burst_len = 8'd5; hold = 1'b0;
    step();
    step();
    step();
    req = 4'b0000;
    step();
    req = 4'b1001;
    step();
    n_vec++;
    if ({obs_grant, obs_en, obs_done} !== 9'b0) begin
      n_err++;
      $display("FAIL abort_gap: grant=%b en=%b done=%b, expected all zero", obs_grant, obs_en, obs_done);
    end
    step();
    n_vec++;
    if (obs_grant !== 4'b1000) begin
      n_err++;
      $display("FAIL abort_ptr: grant=%b, expected 1000", obs_grant);
    end
    step();
    reset_n = 1'b0;
    step();
    step();
    n_vec++;
    if ({obs_grant, obs_busy, obs_en, obs_done} !== 10'b0) begin
      n_err++;
      $display("FAIL midburst_reset: grant=%b busy=%b en=%b done=%b, expected all zero", obs_grant, obs_busy, obs_en, obs_done);
    end
    reset_n = 1'b1;
    step();
    step();
    n_vec++;
    if (obs_grant !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_ptr: grant=%b, expected 0001", obs_grant);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_numreq2();
    apply_reset();
    req2 = 4'b1100; burst_len = 8'd3; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if ({grant2, busy2, en2} !== 6'b0) begin
        n_err++;
        $display("FAIL numreq2_ignore%0d: grant=%b busy=%b en=%b, expected all zero", i, grant2, busy2, en2);
      end
    end
    req2 = 4'b0011;
    step();
    n_vec++;
    if ({grant2, busy2} !== {4'b0001, 1'b1}) begin
      n_err++;
      $display("FAIL numreq2_grant: grant=%b busy=%b, expected grant=0001 busy=1", grant2, busy2);
    end
    req2 = 4'b0000;
    step();
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 4) == 0) req = 4'($urandom);
      hold      = ($urandom_range(0, 3) == 0);
      burst_len = ($urandom_range(0, 99) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      reset_n   = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1'b1; req = 4'b0000; hold = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_zero_length();
    test_abort_and_reset();
    test_numreq2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
